spi_evt_wb_bridge: RTL and testbench
====================================

# spi_evt_wb_bridge

Parametrised Wishbone bridge that captures register-transaction events from the SPI FIFO front end into a capture FIFO of configurable depth and width. The Caravel management core drains the FIFO over Wishbone instead of sampling the SPI outputs directly. It sits beside `spi_fifo_top` inside `wrapped_spi_fifo` and replaces the fixed-width `wb_slave`. New behaviour:

- depth buffering with an overflow flag
- a CRC snapshot taken on every captured event
- a threshold/overflow interrupt

## Interface

Parameters:
- `DATA_W`, default 16, register-data width; 1+`ADR_W`+`DATA_W` ≤ 31.
- `ADR_W`, default 8, register-address width.
- `DEPTH`, default 8, FIFO entries; power of two, ≥ 2.
- `BASE_ADR`, default 32'h3000_0000, Wishbone base; decode on `wbs_adr_i[31:4]`.

Ports:
- `wb_clk_i`, in, 1: the only clock.
- `rstb`, in, 1: asynchronous, active-low reset.
- `evt_valid`, in, 1: SPI transaction-valid level, synchronous to `wb_clk_i`.
- `evt_data`, in, `DATA_W`: register data.
- `evt_adr`, in, `ADR_W`: register address.
- `evt_rwb`, in, 1: 1 = read, 0 = write.
- `crc_in`, in, 16: running CRC from the SPI block.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`, in, 1 each: Wishbone strobe, cycle and write enable.
- `wbs_sel_i`, in, 4: byte-lane select.
- `wbs_dat_i`, in, 32: write data.
- `wbs_adr_i`, in, 32: byte address.
- `wbs_ack_o`, out, 1: acknowledge.
- `wbs_dat_o`, out, 32: read data.
- `irq_o`, out, 1: interrupt, active high.

## Operation

Event capture:
- Push when `evt_valid`=1, registered `evt_prev`=0 and `CTRL.en`=1.
- Entry is `{evt_rwb, evt_adr, evt_data}`.
- On the same edge, `crc_snap` ← `crc_in`.
- `evt_prev` tracks `evt_valid` every cycle, whatever `en` is.

Registers (offset = `wbs_adr_i[3:2]`):
- 0x0 DATA (RO):
  - Not empty: returns the head entry zero-extended, with bit31=0, and pops it.
  - Empty: returns 32'h8000_0000 and does not pop.
  - Writes are ignored.
- 0x4 STATUS:
  - `[7:0]` level; `[16]` empty; `[17]` full; `[18]` overflow, sticky; `[19]` `irq_o`.
  - Writing 1 to bit 18 with `sel[2]`=1 clears overflow.
- 0x8 CTRL (RW, byte lanes per `wbs_sel_i`):
  - `[0]` en; `[1]` clear, self-clearing and reads 0; `[2]` irq_en; `[15:8]` thr.
  - Clear flushes the FIFO (pointers and level to 0) and clears overflow.
- 0xC CRC (RO): `{16'b0, crc_snap}`.
- Address outside `BASE_ADR..BASE_ADR+0xF`: acked, reads return 0, writes have no effect.

FIFO rules:
- Push on full without a simultaneous pop: entry dropped, overflow ← 1, `crc_snap` not updated.
- Push and pop in the same cycle, including when full: both happen, level unchanged.
- Pointers are log2(`DEPTH`) bits wide and wrap naturally. Level is a separate counter, 0..`DEPTH`.
- Clear in the same cycle as a push: clear wins, the FIFO ends empty and overflow = 0.
- Clear in the same cycle as a DATA pop: the read returns the pre-clear head; the FIFO ends empty.

Interrupt:
- `irq_o` is registered: `irq_en` & (overflow | (thr≠0 & level ≥ thr)).

Reset (`rstb`=0, asynchronous):
- `wbs_ack_o`=0, `wbs_dat_o`=0, `irq_o`=0.
- FIFO empty, CTRL=0, overflow=0, `crc_snap`=0, `evt_prev`=0.
- Reset mid-transfer aborts the cycle; no ack is issued.

## Timing

- Wishbone:
  - `wbs_ack_o` rises on the edge after `stb`&`cyc` is first sampled with `ack`=0.
  - It is a one-cycle pulse: `ack` ← `stb`&`cyc`&!`ack`. Back-to-back accesses therefore take 2 cycles each.
  - `wbs_dat_o` is registered and valid while `ack`=1; it holds its value otherwise.
- Register updates, DATA pop and clear happen on the edge that raises `ack`.
- Push latency: an `evt_valid` rise sampled at edge n shows in level/STATUS after edge n. The earliest DATA read returns it with ack at edge n+2.
- `irq_o` updates one cycle after the level/overflow change.
- `evt_valid` held high produces exactly one push. It must fall for ≥1 cycle before the next event.

## Test plan

- Reset, then read STATUS → 32'h0001_0000 (empty); read CTRL → 0; `irq_o`=0.
- en=1; 3 events (adr 0x12/0x34/0x56, data 0xA5A5/0x0001/0xFFFF, rwb 0/1/0) → STATUS level 3. The DATA reads then return, in order:
  - 0x0012_A5A5
  - 0x0134_0001
  - 0x0056_FFFF

  A 4th read returns 0x8000_0000.
- `DEPTH`=8: 10 events, no reads → level 8, full=1, overflow=1. The DATA reads return the first 8 events; CRC equals `crc_in` at the 8th push. W1C bit 18 clears overflow.
- thr=4, irq_en=1: 4 events → `irq_o` rises 1 cycle after the 4th push. One DATA read → `irq_o` falls.
- Event edge coinciding with a DATA read on a full FIFO → level stays 8, no overflow. Clear coinciding with an event edge → level 0.
- Assert `rstb` low while `stb`/`cyc` are held → no ack. After release, the FIFO is empty and the first ack arrives 1 cycle after `stb` is sampled.

Source files
------------

// File: rtl/spi_evt_wb_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_evt_wb_bridge_if
// Description : Wishbone slave bus bundle for the SPI event capture bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_evt_wb_bridge_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_evt_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_evt_wb_bridge
// Description : Captures SPI register-transaction events into a FIFO drained
//               over Wishbone, with CRC snapshot, overflow flag and interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_evt_wb_bridge #(
    parameter int          DATA_W   = 16,
    parameter int          ADR_W    = 8,
    parameter int          DEPTH    = 8,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  wire logic              wb_clk_i,
    input  wire logic              rstb,
    input  wire logic              evt_valid,
    input  wire logic [DATA_W-1:0] evt_data,
    input  wire logic [ADR_W-1:0]  evt_adr,
    input  wire logic              evt_rwb,
    input  wire logic [15:0]       crc_in,
    spi_evt_wb_bridge_if.slave     wbs,
    output logic                   irq_o
);
    localparam int c_ENTRY_W = 1 + ADR_W + DATA_W;
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_LVL_W   = $clog2(DEPTH + 1);
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic                 r_evt_prev;
    logic                 r_ovf;
    logic                 r_en;
    logic                 r_irq_en;
    logic [7:0]           r_thr;
    logic [15:0]          r_crc_snap;
    logic                 r_ack;
    logic [31:0]          r_dat;
    logic                 r_irq;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_access;
    logic                 w_hit;
    logic [1:0]           w_reg;
    logic                 w_rd_access;
    logic                 w_wr_access;
    logic                 w_pop;
    logic                 w_ctrl_wr;
    logic                 w_clear;
    logic                 w_ovf_w1c;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_ovf_set;
    logic                 w_thr_hit;
    logic [c_ENTRY_W-1:0] w_head;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == c_FULL_LVL);
    assign w_access    = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~r_ack;
    assign w_hit       = (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign w_reg       = wbs.wbs_adr_i[3:2];
    assign w_rd_access = w_access & w_hit & ~wbs.wbs_we_i;
    assign w_wr_access = w_access & w_hit & wbs.wbs_we_i;
    assign w_pop       = w_rd_access & (w_reg == 2'd0) & ~w_empty;
    assign w_ctrl_wr   = w_wr_access & (w_reg == 2'd2);
    assign w_clear     = w_ctrl_wr & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[1];
    assign w_ovf_w1c   = w_wr_access & (w_reg == 2'd1) & wbs.wbs_sel_i[2] & wbs.wbs_dat_i[18];

    // A full FIFO still accepts a push when the same edge pops the head.
    assign w_push_req  = evt_valid & ~r_evt_prev & r_en;
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_ovf_set   = w_push_req & w_full & ~w_pop;
    assign w_thr_hit   = (r_thr != 8'd0) & (32'(r_level) >= 32'(r_thr));
    assign w_head      = r_mem[r_rd_ptr];

    assign w_unused    = ^{wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3], wbs.wbs_dat_i[31:19],
                           wbs.wbs_dat_i[17:16], wbs.wbs_dat_i[7:3]};

    always_comb begin
        w_rdata = 32'd0;
        if (w_hit) begin
            case (w_reg)
                2'd0:    w_rdata = w_empty ? 32'h8000_0000 : 32'(w_head);
                2'd1:    w_rdata = {12'd0, r_irq, r_ovf, w_full, w_empty, 8'd0, 8'(r_level)};
                2'd2:    w_rdata = {16'd0, r_thr, 5'd0, r_irq_en, 1'b0, r_en};
                default: w_rdata = {16'd0, r_crc_snap};
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {evt_rwb, evt_adr, evt_data};
        end
    end

    always_ff @(posedge wb_clk_i or negedge rstb) begin
        if (!rstb) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_evt_prev <= 1'b0;
            r_ovf      <= 1'b0;
            r_en       <= 1'b0;
            r_irq_en   <= 1'b0;
            r_thr      <= 8'd0;
            r_crc_snap <= 16'd0;
            r_ack      <= 1'b0;
            r_dat      <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            r_evt_prev <= evt_valid;
            r_ack      <= wbs.wbs_stb_i & wbs.wbs_cyc_i & ~r_ack;
            if (w_access) begin
                r_dat <= w_rdata;
            end
            if (w_push) begin
                r_crc_snap <= crc_in;
            end

            // Clear outranks any push or pop landing on the same edge.
            if (w_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: r_level <= r_level;
                endcase
            end

            if (w_clear)        r_ovf <= 1'b0;
            else if (w_ovf_set) r_ovf <= 1'b1;
            else if (w_ovf_w1c) r_ovf <= 1'b0;

            if (w_ctrl_wr) begin
                if (wbs.wbs_sel_i[0]) begin
                    r_en     <= wbs.wbs_dat_i[0];
                    r_irq_en <= wbs.wbs_dat_i[2];
                end
                if (wbs.wbs_sel_i[1]) begin
                    r_thr <= wbs.wbs_dat_i[15:8];
                end
            end

            r_irq <= r_irq_en & (r_ovf | w_thr_hit);
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign irq_o         = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_spi_evt_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_evt_wb_bridge
// Description : Directed vector bench for spi_evt_wb_bridge (DEPTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_evt_wb_bridge;
    localparam logic [31:0] c_BASE   = 32'h3000_0000;
    localparam logic [31:0] c_A_DATA = c_BASE;
    localparam logic [31:0] c_A_STAT = c_BASE + 32'h4;
    localparam logic [31:0] c_A_CTRL = c_BASE + 32'h8;
    localparam logic [31:0] c_A_CRC  = c_BASE + 32'hC;
    localparam int c_OP_RD = 0;
    localparam int c_OP_WR = 1;
    localparam int c_OP_EV = 2;

    typedef struct {
        int          op;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        erwb;
        logic [7:0]  eadr;
        logic [15:0] edata;
        logic [15:0] ecrc;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        evt_valid = 1'b0;
    logic [15:0] evt_data = 16'd0;
    logic [7:0]  evt_adr = 8'd0;
    logic        evt_rwb = 1'b0;
    logic [15:0] crc_in = 16'd0;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    spi_evt_wb_bridge_if wb_if ();

    spi_evt_wb_bridge #(
        .DATA_W   (16),
        .ADR_W    (8),
        .DEPTH    (8),
        .BASE_ADR (c_BASE)
    ) dut (
        .wb_clk_i  (clk),
        .rstb      (rstb),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_adr   (evt_adr),
        .evt_rwb   (evt_rwb),
        .crc_in    (crc_in),
        .wbs       (wb_if.slave),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Caller sits 1 time unit after a rising edge; returns the same way.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                       input logic [3:0] sel, output logic [31:0] rdat);
        int cnt;
        wb_if.wbs_adr_i = adr;
        wb_if.wbs_dat_i = wdat;
        wb_if.wbs_sel_i = sel;
        wb_if.wbs_we_i  = we;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        cnt  = 0;
        rdat = 32'd0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!wb_if.wbs_ack_o && cnt < 8);
        if (!wb_if.wbs_ack_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout adr=%08h: got no ack, expected ack within 8 cycles", adr);
        end else begin
            rdat = wb_if.wbs_dat_o;
        end
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, adr, 32'd0, 4'hF, r);
        check(name, r, exp);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] r;
        bus(1'b1, adr, dat, sel, r);
    endtask

    task automatic evt(input logic [7:0] adr, input logic [15:0] data, input logic rwb,
                       input logic [15:0] crc);
        evt_adr   = adr;
        evt_data  = data;
        evt_rwb   = rwb;
        crc_in    = crc;
        evt_valid = 1'b1;
        @(posedge clk);
        #1;
        evt_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int op, input logic [31:0] adr, input logic [31:0] wdat,
                                input logic [3:0] sel, input logic erwb, input logic [7:0] eadr,
                                input logic [15:0] edata, input logic [15:0] ecrc,
                                input logic [31:0] exp);
        vec_t v;
        v.op = op; v.adr = adr; v.wdat = wdat; v.sel = sel; v.erwb = erwb;
        v.eadr = eadr; v.edata = edata; v.ecrc = ecrc; v.exp = exp;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] r;

        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_sel_i = 4'h0;
        wb_if.wbs_dat_i = 32'd0;
        wb_if.wbs_adr_i = 32'd0;

        vecs.push_back(mk(c_OP_RD, c_A_STAT, 0, 4'hF, 0, 0, 0, 0, 32'h0001_0000));
        vecs.push_back(mk(c_OP_RD, c_A_CTRL, 0, 4'hF, 0, 0, 0, 0, 32'h0000_0000));
        vecs.push_back(mk(c_OP_RD, c_A_CRC,  0, 4'hF, 0, 0, 0, 0, 32'h0000_0000));
        vecs.push_back(mk(c_OP_RD, c_A_DATA, 0, 4'hF, 0, 0, 0, 0, 32'h8000_0000));
        vecs.push_back(mk(c_OP_EV, 0, 0, 0, 0, 8'h99, 16'h1111, 16'hAAAA, 0));
        vecs.push_back(mk(c_OP_RD, c_A_STAT, 0, 4'hF, 0, 0, 0, 0, 32'h0001_0000));
        vecs.push_back(mk(c_OP_WR, c_A_CTRL, 32'h1, 4'hF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(c_OP_RD, c_A_CTRL, 0, 4'hF, 0, 0, 0, 0, 32'h0000_0001));
        vecs.push_back(mk(c_OP_EV, 0, 0, 0, 1'b0, 8'h12, 16'hA5A5, 16'h1111, 0));
        vecs.push_back(mk(c_OP_EV, 0, 0, 0, 1'b1, 8'h34, 16'h0001, 16'h2222, 0));
        vecs.push_back(mk(c_OP_EV, 0, 0, 0, 1'b0, 8'h56, 16'hFFFF, 16'h3333, 0));
        vecs.push_back(mk(c_OP_RD, c_A_STAT, 0, 4'hF, 0, 0, 0, 0, 32'h0000_0003));
        vecs.push_back(mk(c_OP_RD, c_A_CRC,  0, 4'hF, 0, 0, 0, 0, 32'h0000_3333));
        vecs.push_back(mk(c_OP_RD, c_A_DATA, 0, 4'hF, 0, 0, 0, 0, 32'h0012_A5A5));
        vecs.push_back(mk(c_OP_RD, c_A_DATA, 0, 4'hF, 0, 0, 0, 0, 32'h0134_0001));
        vecs.push_back(mk(c_OP_RD, c_A_DATA, 0, 4'hF, 0, 0, 0, 0, 32'h0056_FFFF));
        vecs.push_back(mk(c_OP_RD, c_A_DATA, 0, 4'hF, 0, 0, 0, 0, 32'h8000_0000));
        vecs.push_back(mk(c_OP_RD, c_BASE + 32'h10, 0, 4'hF, 0, 0, 0, 0, 32'h0000_0000));
        vecs.push_back(mk(c_OP_WR, c_A_DATA, 32'hDEAD, 4'hF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(c_OP_RD, c_A_STAT, 0, 4'hF, 0, 0, 0, 0, 32'h0001_0000));
        vecs.push_back(mk(c_OP_WR, c_A_CTRL, 32'h0000_0500, 4'h2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(c_OP_RD, c_A_CTRL, 0, 4'hF, 0, 0, 0, 0, 32'h0000_0501));
        vecs.push_back(mk(c_OP_WR, c_A_CTRL, 32'h0000_0000, 4'h1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(c_OP_RD, c_A_CTRL, 0, 4'hF, 0, 0, 0, 0, 32'h0000_0500));
        vecs.push_back(mk(c_OP_WR, c_BASE + 32'h18, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(c_OP_RD, c_A_CTRL, 0, 4'hF, 0, 0, 0, 0, 32'h0000_0500));
        vecs.push_back(mk(c_OP_WR, c_A_CTRL, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_ack", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        rstb = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            case (vecs[i].op)
                c_OP_RD: rd($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
                c_OP_WR: wr(vecs[i].adr, vecs[i].wdat, vecs[i].sel);
                default: evt(vecs[i].eadr, vecs[i].edata, vecs[i].erwb, vecs[i].ecrc);
            endcase
        end

        // Overflow: 10 events into 8 slots, then drain and W1C.
        for (int i = 0; i < 10; i++) evt(8'(i), 16'h1000 + 16'(i), 1'b0, 16'h0100 + 16'(i));
        rd("ovf_status", c_A_STAT, 32'h0006_0008);
        rd("ovf_crc", c_A_CRC, 32'h0000_0107);
        check("ovf_irq_disabled", {31'd0, irq_o}, 32'd0);
        for (int i = 0; i < 8; i++)
            rd($sformatf("ovf_data%0d", i), c_A_DATA, {8'd0, 8'(i), 16'h1000 + 16'(i)});
        rd("ovf_drained", c_A_STAT, 32'h0005_0000);
        wr(c_A_STAT, 32'h0004_0000, 4'h3);
        rd("w1c_no_lane", c_A_STAT, 32'h0005_0000);
        wr(c_A_STAT, 32'h0004_0000, 4'h4);
        rd("w1c_cleared", c_A_STAT, 32'h0001_0000);

        // Threshold interrupt.
        wr(c_A_CTRL, 32'h0000_0405, 4'hF);
        for (int i = 0; i < 3; i++) evt(8'h60 + 8'(i), 16'h6000 + 16'(i), 1'b0, 16'h0);
        check("irq_below_thr", {31'd0, irq_o}, 32'd0);
        evt_adr = 8'h63; evt_data = 16'h6003; evt_rwb = 1'b0; evt_valid = 1'b1;
        @(posedge clk);
        #1;
        check("irq_same_cycle", {31'd0, irq_o}, 32'd0);
        evt_valid = 1'b0;
        @(posedge clk);
        #1;
        check("irq_rise", {31'd0, irq_o}, 32'd1);
        rd("irq_status", c_A_STAT, 32'h0008_0004);
        rd("irq_pop", c_A_DATA, 32'h0060_6000);
        @(posedge clk);
        #1;
        check("irq_fall", {31'd0, irq_o}, 32'd0);
        for (int i = 1; i < 4; i++) rd("irq_drain", c_A_DATA, {8'd0, 8'h60 + 8'(i), 16'h6000 + 16'(i)});
        wr(c_A_CTRL, 32'h0000_0001, 4'hF);

        // Push and pop on the same edge with a full FIFO.
        for (int i = 0; i < 8; i++) evt(8'h20 + 8'(i), 16'h2000 + 16'(i), 1'b0, 16'h0);
        evt_adr = 8'h77; evt_data = 16'h7777; evt_rwb = 1'b0; evt_valid = 1'b1;
        wb_if.wbs_adr_i = c_A_DATA; wb_if.wbs_we_i = 1'b0; wb_if.wbs_sel_i = 4'hF;
        wb_if.wbs_stb_i = 1'b1; wb_if.wbs_cyc_i = 1'b1;
        @(posedge clk);
        #1;
        check("pp_ack", {31'd0, wb_if.wbs_ack_o}, 32'd1);
        check("pp_data", wb_if.wbs_dat_o, 32'h0020_2000);
        wb_if.wbs_stb_i = 1'b0; wb_if.wbs_cyc_i = 1'b0; evt_valid = 1'b0;
        @(posedge clk);
        #1;
        rd("pp_status", c_A_STAT, 32'h0002_0008);
        for (int i = 1; i < 8; i++) wr(c_BASE + 32'h10, 32'd0, 4'h0);
        for (int i = 1; i < 8; i++) begin
            bus(1'b0, c_A_DATA, 32'd0, 4'hF, r);
        end
        rd("pp_last", c_A_DATA, 32'h0077_7777);
        rd("pp_empty", c_A_STAT, 32'h0001_0000);

        // Clear on the same edge as an event, with overflow pending.
        for (int i = 0; i < 9; i++) evt(8'h40, 16'h4000 + 16'(i), 1'b0, 16'h0);
        rd("clr_pre", c_A_STAT, 32'h0006_0008);
        evt_adr = 8'h41; evt_data = 16'h4141; evt_valid = 1'b1;
        wr(c_A_CTRL, 32'h0000_0003, 4'hF);
        evt_valid = 1'b0;
        @(posedge clk);
        #1;
        rd("clr_status", c_A_STAT, 32'h0001_0000);
        rd("clr_ctrl", c_A_CTRL, 32'h0000_0001);
        evt(8'h5A, 16'hBEEF, 1'b0, 16'hC0DE);
        rd("post_clr_status", c_A_STAT, 32'h0000_0001);
        rd("post_clr_crc", c_A_CRC, 32'h0000_C0DE);

        // Reset in the middle of a held bus cycle.
        wb_if.wbs_adr_i = c_A_STAT; wb_if.wbs_we_i = 1'b0; wb_if.wbs_sel_i = 4'hF;
        wb_if.wbs_stb_i = 1'b1; wb_if.wbs_cyc_i = 1'b1;
        #2;
        rstb = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rstx_ack", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        end
        check("rstx_dat", wb_if.wbs_dat_o, 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        check("rstx_first_ack", {31'd0, wb_if.wbs_ack_o}, 32'd1);
        check("rstx_status", wb_if.wbs_dat_o, 32'h0001_0000);
        @(posedge clk);
        #1;
        check("rstx_ack_pulse", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        wb_if.wbs_stb_i = 1'b0; wb_if.wbs_cyc_i = 1'b0;
        @(posedge clk);
        #1;
        rd("rstx_crc", c_A_CRC, 32'h0000_0000);
        rd("rstx_ctrl", c_A_CTRL, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
